// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI mode-0 master that shifts a 16-bit frame
// {addr[6:0], rw, data[7:0]} MSB first and returns the read byte with a
// one-cycle done pulse. All outputs are registered.
// Optional feature: define SPI_MASTER_FAULT_ABORT_EN to let a synchronized
// fault input abort an in-flight frame (done=1, error=1).
module spi_master_driver #(
  parameter int HALF_PERIOD = 16,
  parameter int GAP_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  input  logic       fault
);

  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0]    half, half_nx;
  logic [15:0]   sreg, sreg_nx;
  logic [7:0]    rreg, rreg_nx;
  logic          is_read, is_read_nx;
  logic          busy_nx, done_nx, error_nx, cs_nx, sclk_nx, mosi_nx;
  logic [7:0]    rdata_nx;
  logic [1:0]    miso_sync;
  logic          abort;

  // Two-flop synchronizer for the asynchronous miso line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking <= so every flop samples pre-edge values.
    if (reset) miso_sync <= '0;
    else       miso_sync <= {miso_sync[0], miso};
  end

`ifdef SPI_MASTER_FAULT_ABORT_EN
  logic [1:0] fault_sync;

  // Two-flop synchronizer for the asynchronous fault request.
  always_ff @(posedge clk) begin
    if (reset) fault_sync <= '0;
    else       fault_sync <= {fault_sync[0], fault};
  end

  assign abort = fault_sync[1];
`else
  logic unused_fault;

  assign unused_fault = fault;
  assign abort        = 1'b0;
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (that would infer a latch).
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    half_nx    = half;
    sreg_nx    = sreg;
    rreg_nx    = rreg;
    is_read_nx = is_read;
    busy_nx    = busy;
    done_nx    = 1'b0;
    error_nx   = 1'b0;
    cs_nx      = cs;
    sclk_nx    = sclk;
    mosi_nx    = mosi;
    rdata_nx   = rdata;

    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start) begin
          // Read frames carry zeros in the data phase.
          sreg_nx    = {addr, rw, rw ? 8'h00 : wdata};
          is_read_nx = rw;
          half_nx    = '0;
          busy_nx    = 1'b1;
          cs_nx      = 1'b0;
          mosi_nx    = addr[6];
          state_nx   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == HALF_LAST) begin
          cnt_nx   = '0;
          half_nx  = '0;
          sclk_nx  = 1'b1;  // rising edge 1
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == HALF_LAST) begin
          cnt_nx  = '0;
          half_nx = half + 5'd1;
          if (!half[0]) begin
            // End of a high phase: falling edge, present the next frame bit.
            sclk_nx = 1'b0;
            sreg_nx = {sreg[14:0], 1'b0};
            mosi_nx = sreg[14];
          end else if (half == 5'd31) begin
            state_nx = S_HOLD;
          end else begin
            // Rising edge k = (half+1)/2 + 1; data bits arrive on k = 9..16.
            sclk_nx = 1'b1;
            if (is_read && half >= 5'd15) rreg_nx = {rreg[6:0], miso_sync[1]};
          end
        end
      end
      S_HOLD: begin
        if (cnt == HALF_LAST) begin
          cnt_nx   = '0;
          cs_nx    = 1'b1;
          done_nx  = 1'b1;
          if (is_read) rdata_nx = rreg;
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          busy_nx  = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // An abort ends the frame at once and still honours the inter-frame gap.
    if (abort && (state inside {S_SETUP, S_SHIFT, S_HOLD})) begin
      cnt_nx   = '0;
      cs_nx    = 1'b1;
      sclk_nx  = 1'b0;
      mosi_nx  = 1'b0;
      done_nx  = 1'b1;
      error_nx = 1'b1;
      rdata_nx = rdata;
      state_nx = S_GAP;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shift/read registers are reset too; they are small and this keeps X out of simulation.
      state   <= S_IDLE;
      cnt     <= '0;
      half    <= '0;
      sreg    <= '0;
      rreg    <= '0;
      is_read <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      half    <= half_nx;
      sreg    <= sreg_nx;
      rreg    <= rreg_nx;
      is_read <= is_read_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      error   <= error_nx;
      cs      <= cs_nx;
      sclk    <= sclk_nx;
      mosi    <= mosi_nx;
      rdata   <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: directed bench for spi_master_driver. Two instances
// share the inputs (HALF_PERIOD 16 and 8); sel8 picks which one is observed.
module tb_spi_master_driver;

  localparam int M_NORMAL = 0;
  localparam int M_PULSE  = 1;
  localparam int M_HOLD   = 2;
  localparam int M_RESET  = 3;
  localparam int M_FAULT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       miso = 1'b0;
  logic       fault = 1'b0;
  logic       sel8 = 1'b0;

  logic       busy, done, error, cs, sclk, mosi;
  logic [7:0] rdata;
  logic       busy8, done8, error8, cs8, sclk8, mosi8;
  logic [7:0] rdata8;

  logic       o_busy, o_done, o_error, o_cs, o_sclk, o_mosi;
  logic [7:0] o_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Results recorded by run_xfer.
  logic [15:0] r_bits;
  int          r_done_cyc, r_done_cnt, r_cs_low, r_busy_low, r_viol, r_cs2, r_fault_n;
  logic        r_err, r_cs_at_done;
  logic [7:0]  r_rdata;
  logic        rs_cs, rs_sclk, rs_busy, rs_done, rs_mosi;
  logic [7:0]  rs_rdata;

  always #10 clk = ~clk;

  spi_master_driver dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .error(error), .rdata(rdata),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso), .fault(fault)
  );

  spi_master_driver #(.HALF_PERIOD(8), .GAP_CYCLES(32)) dut8 (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy8), .done(done8), .error(error8), .rdata(rdata8),
    .cs(cs8), .sclk(sclk8), .mosi(mosi8), .miso(miso), .fault(fault)
  );

  assign o_busy  = sel8 ? busy8  : busy;
  assign o_done  = sel8 ? done8  : done;
  assign o_error = sel8 ? error8 : error;
  assign o_cs    = sel8 ? cs8    : cs;
  assign o_sclk  = sel8 ? sclk8  : sclk;
  assign o_mosi  = sel8 ? mosi8  : mosi;
  assign o_rdata = sel8 ? rdata8 : rdata;

  // Issue one request and watch the selected DUT; n counts cycles after T0.
  task automatic run_xfer(input logic r, input logic [6:0] a, input logic [7:0] wd,
                          input logic [7:0] sb, input int mode, input int budget);
    int   n, nrise, nfall;
    logic prev_sclk, prev_mosi, pulse_clr, rst_pend;
    r_bits = '0; r_done_cyc = 0; r_done_cnt = 0; r_cs_low = 0; r_busy_low = 0;
    r_viol = 0; r_cs2 = 0; r_fault_n = 0; r_err = 1'b0; r_cs_at_done = 1'b0; r_rdata = '0;
    @(negedge clk);
    rw = r; addr = a; wdata = wd; miso = 1'b0; start = 1'b1;
    @(posedge clk);
    n = 0; nrise = 0; nfall = 0;
    prev_sclk = 1'b0; prev_mosi = 1'b0; pulse_clr = 1'b0; rst_pend = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (mode == M_RESET && rst_pend) begin
        rs_cs = o_cs; rs_sclk = o_sclk; rs_busy = o_busy; rs_done = o_done;
        rs_mosi = o_mosi; rs_rdata = o_rdata;
        reset = 1'b0;
        break;
      end
      if (mode != M_HOLD && n == 1) start = 1'b0;
      if (pulse_clr) begin start = 1'b0; pulse_clr = 1'b0; end
      if (o_sclk && !prev_sclk) begin
        nrise++;
        if (nrise <= 16) r_bits[16-nrise] = o_mosi;
      end
      if (!o_sclk && prev_sclk) begin
        nfall++;
        if (r && nfall >= 8 && nfall <= 15) miso = sb[15-nfall];
      end
      if (n > 1 && o_mosi !== prev_mosi && !(prev_sclk && !o_sclk)) r_viol++;
      if (!o_cs && r_done_cnt == 0) r_cs_low++;
      if (o_done) begin
        r_done_cnt++;
        if (r_done_cnt == 1) begin
          r_done_cyc = n; r_err = o_error; r_rdata = o_rdata; r_cs_at_done = o_cs;
          if (mode == M_PULSE) begin start = 1'b1; pulse_clr = 1'b1; end
        end
        fault = 1'b0;
      end
      if (mode == M_PULSE && n == 100) begin start = 1'b1; pulse_clr = 1'b1; end
      if (mode == M_RESET && nrise == 5 && !rst_pend) begin reset = 1'b1; rst_pend = 1'b1; end
      if (mode == M_FAULT && nrise == 10 && r_fault_n == 0) begin fault = 1'b1; r_fault_n = n; end
      if (mode == M_FAULT && nfall == 10) fault = 1'b0;
      if (r_done_cnt > 0 && !o_busy && r_busy_low == 0) begin
        r_busy_low = n;
        if (mode != M_HOLD) break;
      end
      if (mode == M_HOLD && r_busy_low > 0 && !o_cs) begin r_cs2 = n; break; end
      if (n >= budget) begin
        n_cmp++; n_fail++;
        $display("FAIL xfer_timeout: no completion after %0d cycles (mode %0d)", n, mode);
        break;
      end
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
    end
    start = 1'b0; miso = 1'b0; fault = 1'b0; reset = 1'b0;
  endtask

  // Wait (bounded) until both instances are idle.
  task automatic wait_idle();
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy && !busy8 && cs && cs8) break;
    end
    if (k >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle: DUT still busy after %0d cycles", k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({o_cs, o_sclk, o_mosi, o_busy, o_done, o_error} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 100000", {o_cs, o_sclk, o_mosi, o_busy, o_done, o_error});
    end
    n_cmp++; if (o_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00", o_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_xfer(1'b0, 7'h34, 8'hFA, 8'h00, M_NORMAL, 700);
    n_cmp++; if (r_bits !== 16'h68FA) begin n_fail++; $display("FAIL write_bits: got %h want 68fa", r_bits); end
    n_cmp++; if (r_done_cyc !== 545) begin n_fail++; $display("FAIL write_done_cyc: got %0d want 545", r_done_cyc); end
    n_cmp++; if (r_cs_low !== 544) begin n_fail++; $display("FAIL write_cs_low: got %0d want 544", r_cs_low); end
    n_cmp++; if (r_err !== 1'b0 || r_cs_at_done !== 1'b1) begin
      n_fail++; $display("FAIL write_err_cs: got err=%b cs=%b want err=0 cs=1", r_err, r_cs_at_done);
    end
    n_cmp++; if (r_busy_low !== 577) begin n_fail++; $display("FAIL write_busy_low: got %0d want 577", r_busy_low); end
    n_cmp++; if (r_viol !== 0) begin n_fail++; $display("FAIL write_mosi_edges: got %0d stray changes want 0", r_viol); end
    wait_idle();
  endtask

  task automatic test_read();
    run_xfer(1'b1, 7'h34, 8'h5A, 8'hFA, M_NORMAL, 700);
    n_cmp++; if (r_bits !== 16'h6900) begin n_fail++; $display("FAIL read_bits: got %h want 6900", r_bits); end
    n_cmp++; if (r_rdata !== 8'hFA) begin n_fail++; $display("FAIL read_rdata: got %h want fa", r_rdata); end
    n_cmp++; if (r_done_cyc !== 545) begin n_fail++; $display("FAIL read_done_cyc: got %0d want 545", r_done_cyc); end
    wait_idle();
    run_xfer(1'b0, 7'h12, 8'h33, 8'h00, M_NORMAL, 700);
    n_cmp++; if (r_bits !== 16'h2433) begin n_fail++; $display("FAIL write2_bits: got %h want 2433", r_bits); end
    n_cmp++; if (r_rdata !== 8'hFA) begin n_fail++; $display("FAIL write_keeps_rdata: got %h want fa", r_rdata); end
    wait_idle();
  endtask

  task automatic test_busy_gap();
    int cs_low_after;
    run_xfer(1'b0, 7'h34, 8'hFA, 8'h00, M_PULSE, 700);
    n_cmp++; if (r_done_cnt !== 1 || r_done_cyc !== 545) begin
      n_fail++; $display("FAIL gap_pulse_done: got cnt=%0d cyc=%0d want 1/545", r_done_cnt, r_done_cyc);
    end
    cs_low_after = 0;
    repeat (10) begin
      @(negedge clk);
      if (!o_cs || o_busy) cs_low_after++;
    end
    n_cmp++; if (cs_low_after !== 0) begin
      n_fail++; $display("FAIL gap_pulse_ignored: got %0d active cycles want 0", cs_low_after);
    end
    wait_idle();
    run_xfer(1'b0, 7'h34, 8'hFA, 8'h00, M_HOLD, 700);
    n_cmp++; if (r_cs2 !== 578) begin n_fail++; $display("FAIL gap_hold_cs2: got %0d want 578", r_cs2); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int stray;
    run_xfer(1'b0, 7'h34, 8'hFA, 8'h00, M_RESET, 700);
    n_cmp++; if ({rs_cs, rs_sclk, rs_busy, rs_done, rs_mosi} !== 5'b10000) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %b want 10000", {rs_cs, rs_sclk, rs_busy, rs_done, rs_mosi});
    end
    n_cmp++; if (rs_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 00", rs_rdata); end
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done || !o_cs) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", stray); end
    wait_idle();
    run_xfer(1'b0, 7'h2A, 8'h55, 8'h00, M_NORMAL, 700);
    n_cmp++; if (r_bits !== 16'h5455 || r_done_cyc !== 545) begin
      n_fail++; $display("FAIL rstmid_recover: got bits=%h done=%0d want 5455/545", r_bits, r_done_cyc);
    end
    wait_idle();
  endtask

  task automatic test_fault();
    run_xfer(1'b1, 7'h34, 8'h00, 8'hFA, M_NORMAL, 700);
    wait_idle();
    run_xfer(1'b1, 7'h34, 8'h00, 8'h0F, M_FAULT, 700);
    n_cmp++; if (r_fault_n !== 305) begin n_fail++; $display("FAIL fault_rise10_cyc: got %0d want 305", r_fault_n); end
`ifdef SPI_MASTER_FAULT_ABORT_EN
    n_cmp++; if (r_done_cnt !== 1 || r_done_cyc - r_fault_n > 3 || r_done_cyc <= r_fault_n) begin
      n_fail++; $display("FAIL fault_done_latency: got done=%0d fault=%0d want within 3", r_done_cyc, r_fault_n);
    end
    n_cmp++; if (r_err !== 1'b1 || r_cs_at_done !== 1'b1) begin
      n_fail++; $display("FAIL fault_err_cs: got err=%b cs=%b want 1/1", r_err, r_cs_at_done);
    end
    n_cmp++; if (r_rdata !== 8'hFA) begin n_fail++; $display("FAIL fault_rdata: got %h want fa", r_rdata); end
`else
    n_cmp++; if (r_done_cyc !== 545 || r_err !== 1'b0) begin
      n_fail++; $display("FAIL fault_ignored: got done=%0d err=%b want 545/0", r_done_cyc, r_err);
    end
    n_cmp++; if (r_rdata !== 8'h0F) begin n_fail++; $display("FAIL fault_ignored_rdata: got %h want 0f", r_rdata); end
`endif
    wait_idle();
  endtask

  task automatic test_half_period8();
    sel8 = 1'b1;
    run_xfer(1'b0, 7'h00, 8'h7F, 8'h00, M_NORMAL, 400);
    n_cmp++; if (r_bits !== 16'h007F) begin n_fail++; $display("FAIL hp8_bits: got %h want 007f", r_bits); end
    n_cmp++; if (r_cs_low !== 272) begin n_fail++; $display("FAIL hp8_cs_low: got %0d want 272", r_cs_low); end
    n_cmp++; if (r_done_cyc !== 273 || r_busy_low !== 305) begin
      n_fail++; $display("FAIL hp8_timing: got done=%0d busy_low=%0d want 273/305", r_done_cyc, r_busy_low);
    end
    sel8 = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_gap();
    test_reset_mid();
    test_fault();
    test_half_period8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_driver.md
# spi_master_driver

Host-side SPI master that generates the serial transactions consumed by the mp2 SPI slave memory. It takes a parallel request (7-bit address, R/W bit, 8-bit data), drives CS/SCLK/MOSI in SPI mode 0, captures MISO on reads and returns the byte with a completion pulse. It sits directly upstream of the slave's MOSI/SCLK/CS pins and downstream of its MISO pin, and provides on-chip stimulus and loopback for board-level bring-up.

## Interface
- `HALF_PERIOD`, default 16: `clk` cycles per SCLK half period. Must be ≥ 8, which leaves margin for the slave's input synchronizers.
- `GAP_CYCLES`, default 32: minimum number of `clk` cycles CS stays high between transactions.
- `clk`  input  1  system clock, 50 MHz.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request strobe. Sampled only in IDLE.
- `rw`  input  1  0 = write, 1 = read.
- `addr`  input  7  target address.
- `wdata`  input  8  write data. Ignored for reads.
- `busy`  output  1  high from the cycle after an accepted `start` until the block returns to IDLE.
- `done`  output  1  one-cycle completion pulse.
- `error`  output  1  valid with `done`. Set to 1 when the transaction was aborted by `fault`.
- `rdata`  output  8  read byte. Valid from `done` and held until the next read completes.
- `cs`  output  1  chip select, active low.
- `sclk`  output  1  serial clock, idle low.
- `mosi`  output  1  serial data to the slave.
- `miso`  input  1  serial data from the slave, asynchronous. Passes through a 2-flop synchronizer before use.
- `fault`  input  1  abort request, asynchronous. Passes through a 2-flop synchronizer before use.

## Operation
- Frame is 16 bits, MSB first: `addr[6:0]`, then `rw`, then 8 data bits.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- **IDLE:** `cs`=1, `sclk`=0, `mosi`=0, `busy`=0. On `start`=1:
  - latch `{addr, rw, wdata}` into a 16-bit shift register;
  - go to SETUP.
- **SETUP:**
  - `cs`=0, `mosi`=frame bit 15 (`addr[6]`);
  - hold for HALF_PERIOD cycles, then go to SHIFT.
- **SHIFT:** lasts 32 half periods, i.e. 16 rising edges and 16 falling edges of `sclk`.
  - Rising edge k (k = 1..16): for reads, if k ≥ 9, shift synchronized `miso` into the read register.
  - Falling edge: shift `mosi` to the next frame bit.
  - After the 16th falling edge, go to HOLD.
  - During the data phase of a read, `mosi` = 0.
- **HOLD:**
  - `sclk`=0, `cs`=0 for HALF_PERIOD cycles;
  - then `cs`=1 and `done`=1 for one cycle;
  - `rdata` loaded from the read register on reads only;
  - go to GAP.
- **GAP:** `cs`=1, `busy` stays 1 for GAP_CYCLES cycles, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Reset, in any state including mid-frame, gives next cycle: IDLE, `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `error`=0, `rdata`=0x00. No `done` pulse is issued for the killed frame.

## Timing
- Call the cycle in which `start` is sampled high T0.
- T0+1: `cs` falls, `busy` rises, `mosi` = `addr[6]`.
- First `sclk` rise at T0+1+HALF_PERIOD; rising edges then follow every 2·HALF_PERIOD cycles.
- `cs` is low for exactly 34·HALF_PERIOD cycles: 544 at the default.
- `done` occurs at T0+1+34·HALF_PERIOD: T0+545 at the default.
- `busy` falls GAP_CYCLES cycles after `done`: T0+577 at the default.
- The earliest next `start` is accepted in the first IDLE cycle, which is the cycle `busy` is low.
- Every output is registered. `mosi` changes only in cycles where `sclk` falls, or at SETUP entry.

## Configuration
- `SPI_MASTER_FAULT_ABORT_EN` defined:
  - synchronized `fault`=1 in SETUP, SHIFT or HOLD aborts the frame;
  - next cycle: `cs`=1, `sclk`=0, `mosi`=0, `done`=1, `error`=1, `rdata` unchanged;
  - then GAP as normal.
- `SPI_MASTER_FAULT_ABORT_EN` undefined:
  - `fault` is ignored and no synchronizer is built for it;
  - `error` is tied to 0.

## Test plan
- **Write:** `addr`=0x34, `rw`=0, `wdata`=0xFA.
  - MOSI sampled on `sclk` rises is 0110100_0_11111010.
  - `done` at T0+545; `cs` low for 544 cycles; `error`=0.
- **Read:** `addr`=0x34, `rw`=1, slave model returns 0xFA on `miso`.
  - MOSI bits 1..8 are 0110100_1; bits 9..16 are 0.
  - `rdata`=0xFA at `done`.
  - A subsequent write leaves `rdata`=0xFA.
- **Busy/gap:** `start` pulsed at T0+100 and again at the `done` cycle → both ignored. `start` held high continuously → second `cs` fall at T0+578.
- **Reset mid-frame:** assert `reset` after the 5th `sclk` rise → next cycle `cs`=1, `sclk`=0, `busy`=0, no `done`. A new write then completes normally.
- **Fault** (macro defined): `fault`=1 during the 10th `sclk` high phase → `done`=1, `error`=1 within 3 cycles; `cs`=1; `rdata` unchanged. With the macro undefined, the same stimulus completes the frame with `error`=0.
- **HALF_PERIOD**=8: write of 0x7F to 0x00 → `cs` low for 272 cycles; bit pattern correct.
